// File: rtl/spi_mem_ctrl_pkg.sv
// Shared encodings for the SPI memory controller: frame layout, commands, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_mem_ctrl_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WR_MEM  = 2'b01,
    RD_REQ  = 2'b10,
    RD_WAIT = 2'b11
  } state_e;

  // rx_data layout: [9:8] command, [7:0] payload
  typedef struct packed {
    cmd_e              cmd;
    logic [DATA_W-1:0] payload;
  } frame_t;

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Bundle of SPI-frame, read-back and memory-port signals around the controller.
// Latency: n/a (wires only).
// Backpressure: none; the SPI side drops frames the controller is too busy to take.
// Ports: master = controller view (drives tx_*, mem_*, cmd_err); slave = environment view.
interface spi_mem_ctrl_if import spi_mem_ctrl_pkg::*; #(
  parameter int ADDR_SIZE = 8
) ();

  logic [FRAME_W-1:0]   rx_data;
  logic                 rx_valid;
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_valid;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_we;
  logic                 mem_re;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 cmd_err;

  modport master (
    input  rx_data, rx_valid, mem_rdata,
    output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, cmd_err
  );

  modport slave (
    output rx_data, rx_valid, mem_rdata,
    input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, cmd_err
  );

endinterface

// File: rtl/spi_mem_ctrl_rise_detect.sv
// Registered rising-edge detector for the level-style frame-complete flag.
// Latency: rise is combinational from din against last cycle's registered value.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), din (level), rise (one-cycle pulse).
module spi_mem_ctrl_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;
  logic hist_vld;

  // hist_vld keeps the first post-reset cycle from treating a level that was
  // already high through reset as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= 1'b0;
      hist_vld <= 1'b0;
    end else begin
      prev     <= din;
      hist_vld <= 1'b1;
    end
  end

  assign rise = hist_vld & din & ~prev;

endmodule

// File: rtl/spi_mem_ctrl.sv
// Decodes SPI frames into memory address loads, writes and armed reads.
// Latency: write strobe T+1; read strobe T+1, tx_valid/tx_data T+3 after accept at T.
// Backpressure: none; frames arriving while busy are dropped with a cmd_err pulse.
// Ports: clk, rst (sync, active-high), bus (spi_mem_ctrl_if.master).
module spi_mem_ctrl import spi_mem_ctrl_pkg::*; #(
  parameter int ADDR_SIZE     = 8,
  parameter bit ADDR_AUTO_INC = 1'b0
) (
  input logic            clk,
  input logic            rst,
  spi_mem_ctrl_if.master bus
);

  state_e               state, state_nxt;
  frame_t               frame;
  logic                 rx_rise, accept;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, payload_addr;
  logic                 rd_armed;
  logic [DATA_W-1:0]    wdata_q, tx_data_q;
  logic                 tx_valid_q, cmd_err_q;
  logic                 mem_we_c, mem_re_c;
  logic [ADDR_SIZE-1:0] mem_addr_c;
  logic [DATA_W-1:0]    mem_wdata_c;

  assign frame        = frame_t'(bus.rx_data);
  assign payload_addr = ADDR_SIZE'(frame.payload);
  assign accept       = rx_rise && (state == IDLE);

  spi_mem_ctrl_rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.rx_valid),
    .rise (rx_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Memory port is a pure function of state so an aborting reset can never
  // leave a strobe behind.
  always_comb begin
    state_nxt   = state;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (frame.cmd == CMD_WR_DATA)                  state_nxt = WR_MEM;
          else if (frame.cmd == CMD_RD_DATA && rd_armed) state_nxt = RD_REQ;
        end
      end
      WR_MEM: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = wr_addr;
        mem_wdata_c = wdata_q;
        state_nxt   = IDLE;
      end
      RD_REQ: begin
        mem_re_c   = 1'b1;
        mem_addr_c = rd_addr;
        state_nxt  = RD_WAIT;
      end
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      rd_armed   <= 1'b0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      if (rx_rise && state != IDLE) cmd_err_q <= 1'b1;
      if (accept) begin
        // An unarmed read is rejected outright, so it leaves the last read-back intact.
        if (!(frame.cmd == CMD_RD_DATA && !rd_armed)) begin
          tx_valid_q <= 1'b0;
          tx_data_q  <= '0;
        end
        case (frame.cmd)
          CMD_WR_ADDR: wr_addr <= payload_addr;
          CMD_WR_DATA: wdata_q <= frame.payload;
          CMD_RD_ADDR: begin
            rd_addr  <= payload_addr;
            rd_armed <= 1'b1;
          end
          CMD_RD_DATA: if (!rd_armed) cmd_err_q <= 1'b1;
          default: ;
        endcase
      end
      if (state == WR_MEM && ADDR_AUTO_INC) wr_addr <= wr_addr + ADDR_SIZE'(1);
      if (state == RD_WAIT) begin
        tx_data_q  <= bus.mem_rdata;
        tx_valid_q <= 1'b1;
        rd_armed   <= 1'b0;
      end
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_re    = mem_re_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 8: memory address width; the lower 8 bits come from the frame payload and any upper bits are zero-extended.
REQ-002 Parameter ADDR_AUTO_INC, default 0: when 1, the write address increments after each memory write.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_data  input  10  frame from SPI slave; [9:8] = command, [7:0] = payload.
REQ-006 rx_valid  input  1  frame-complete level from SPI slave; may stay high for many cycles.
REQ-007 tx_data  output  8  read byte to SPI slave.
REQ-008 tx_valid  output  1  tx_data is valid.
REQ-009 mem_addr  output  ADDR_SIZE  memory address.
REQ-010 mem_wdata  output  8  memory write data.
REQ-011 mem_we  output  1  memory write strobe, one cycle.
REQ-012 mem_re  output  1  memory read strobe, one cycle; mem_rdata is valid the next cycle.
REQ-013 mem_rdata  input  8  memory read data.
REQ-014 cmd_err  output  1  one-cycle error pulse.

Function
REQ-015 A frame SHALL be accepted only on a rising edge of rx_valid: registered previous value 0, current value 1.
REQ-016 Commands SHALL be: 00 = load wr_addr; 01 = write payload at wr_addr; 10 = load rd_addr and set rd_armed; 11 = read at rd_addr (payload ignored).
REQ-017 FSM states SHALL be IDLE, WR_MEM, RD_REQ, RD_WAIT; frames are accepted only in IDLE.
REQ-018 Commands 00 and 10 SHALL update the register in the accept cycle and remain in IDLE.
REQ-019 Command 01 accepted at cycle T SHALL go to WR_MEM: mem_we=1, mem_addr=wr_addr, mem_wdata=payload at T+1, then IDLE.
REQ-020 With ADDR_AUTO_INC=1, wr_addr SHALL increment after the write and wrap from all-ones to 0.
REQ-021 Command 11 with rd_armed=1 accepted at T SHALL give:
- T+1 (RD_REQ): mem_re=1, mem_addr=rd_addr.
- T+2 (RD_WAIT): capture mem_rdata.
- T+3: tx_data = captured byte, tx_valid=1; clear rd_armed; return to IDLE.
REQ-022 Command 11 with rd_armed=0 SHALL pulse cmd_err at T+1, issue no memory access, and leave tx_valid unchanged.
REQ-023 tx_valid and tx_data SHALL hold until the next accepted frame, and SHALL clear in that frame's accept cycle.
REQ-024 An rx_valid rising edge outside IDLE SHALL be dropped and SHALL pulse cmd_err the next cycle.
REQ-025 mem_we and mem_re SHALL never be high in the same cycle, and both SHALL be 0 in IDLE.
REQ-026 mem_addr SHALL be driven only during WR_MEM and RD_REQ; otherwise it is 0.

Reset
REQ-027 In any cycle with rst=1, the block SHALL set:
- FSM to IDLE;
- tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, cmd_err to 0;
- wr_addr, rd_addr, rd_armed, rx_valid history to 0.
REQ-028 Reset mid-operation, including in RD_REQ or RD_WAIT, SHALL abort with no further memory strobe.
REQ-029 An rx_valid already high when rst deasserts SHALL NOT be accepted.

Structure
REQ-030 A shared package SHALL hold the command encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), the FSM state encodings, and FRAME_W=10.
REQ-031 One sub-module is natural, rise_detect (registered rising-edge detector); all other logic stays flat.

Verification
REQ-032 Send frames 0x0_12 (write address 0x12), then 0x1_A5 (write data) -> mem_we pulses one cycle after the second accept, with mem_addr=0x12 and mem_wdata=0xA5.
REQ-033 Send 0x2_12, then 0x3_00, with memory at 0x12 holding 0xA5 -> mem_re at T+1 with mem_addr=0x12; at T+3 tx_valid=1 and tx_data=0xA5, held until the next frame.
REQ-034 Send 0x3_00 right after reset -> cmd_err pulses at T+1, with no mem_re and tx_valid=0.
REQ-035 Hold rx_valid high for 20 cycles on one frame -> exactly one accept and one memory strobe.
REQ-036 With ADDR_AUTO_INC=1, send address 0xFF then two data writes -> mem_addr is 0xFF, then 0x00.
REQ-037 Assert rst during RD_WAIT, and separately toggle rx_valid during RD_REQ -> reset gives no tx_valid and all outputs 0 the next cycle; the toggle gives a cmd_err pulse and a dropped frame.
